ft232r_reg_bridge: RTL



---
 rtl/ft232r_reg_bridge.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ft232r_reg_bridge.sv
// rtl/ft232r_reg_bridge.sv - byte-command to register-bus bridge behind the FT232R handshake adapter
// Parses 'W' addr dhi dlo / 'R' addr packets into register strobes and returns ACK, NAK or read data.
module ft232r_reg_bridge #(
    parameter int unsigned P_BYTE_TIMEOUT = 12000000,
    parameter int unsigned P_RD_TIMEOUT   = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_req_i,
    output logic        cmd_ack_o,
    input  logic [7:0]  cmd_data_i,
    output logic        rsp_req_o,
    input  logic        rsp_ack_i,
    output logic [7:0]  rsp_data_o,
    output logic [7:0]  reg_addr_o,
    output logic [15:0] reg_wr_data_o,
    output logic        reg_wr_en_o,
    output logic        reg_rd_en_o,
    input  logic [15:0] reg_rd_data_i,
    input  logic        reg_rd_valid_i,
    output logic        busy_o
);

    localparam logic [7:0]  OP_WRITE   = 8'h57;
    localparam logic [7:0]  OP_READ    = 8'h52;
    localparam logic [7:0]  RSP_ACK    = 8'h06;
    localparam logic [7:0]  RSP_NAK    = 8'h15;
    localparam logic [23:0] BYTE_LIMIT = 24'(P_BYTE_TIMEOUT - 1);
    localparam logic [7:0]  RD_LIMIT   = 8'(P_RD_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_ADDR,
        S_GET_DHI,
        S_GET_DLO,
        S_EXEC_WR,
        S_EXEC_RD,
        S_WAIT_RD,
        S_SEND
    } state_t;

    typedef enum logic [1:0] {
        TX_LOAD,
        TX_REQ,
        TX_GAP
    } tx_t;

    state_t      state_q, state_d;
    tx_t         tx_q, tx_d;
    logic        is_wr_q, is_wr_d;
    logic        cmd_ack_q, cmd_ack_d;
    logic        rsp_req_q, rsp_req_d;
    logic [7:0]  rsp_data_q, rsp_data_d;
    logic [7:0]  rsp_lo_q, rsp_lo_d;
    logic        rsp_two_q, rsp_two_d;
    logic [7:0]  reg_addr_q, reg_addr_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic        wr_en_q, wr_en_d;
    logic        rd_en_q, rd_en_d;
    logic [23:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]  rd_cnt_q, rd_cnt_d;

    logic receiving;
    logic in_get;
    logic byte_take;
    logic byte_timeout;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            tx_q       <= TX_LOAD;
            is_wr_q    <= 1'b0;
            cmd_ack_q  <= 1'b0;
            rsp_req_q  <= 1'b0;
            rsp_data_q <= 8'h00;
            rsp_lo_q   <= 8'h00;
            rsp_two_q  <= 1'b0;
            reg_addr_q <= 8'h00;
            wr_data_q  <= 16'h0000;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            byte_cnt_q <= 24'h000000;
            rd_cnt_q   <= 8'h00;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            is_wr_q    <= is_wr_d;
            cmd_ack_q  <= cmd_ack_d;
            rsp_req_q  <= rsp_req_d;
            rsp_data_q <= rsp_data_d;
            rsp_lo_q   <= rsp_lo_d;
            rsp_two_q  <= rsp_two_d;
            reg_addr_q <= reg_addr_d;
            wr_data_q  <= wr_data_d;
            wr_en_q    <= wr_en_d;
            rd_en_q    <= rd_en_d;
            byte_cnt_q <= byte_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        is_wr_d    = is_wr_q;
        cmd_ack_d  = cmd_ack_q;
        rsp_req_d  = rsp_req_q;
        rsp_data_d = rsp_data_q;
        rsp_lo_d   = rsp_lo_q;
        rsp_two_d  = rsp_two_q;
        reg_addr_d = reg_addr_q;
        wr_data_d  = wr_data_q;
        wr_en_d    = 1'b0;
        rd_en_d    = 1'b0;
        byte_cnt_d = 24'h000000;
        rd_cnt_d   = rd_cnt_q;

        in_get    = (state_q == S_GET_ADDR) || (state_q == S_GET_DHI) || (state_q == S_GET_DLO);
        receiving = (state_q == S_IDLE) || in_get;
        byte_take = receiving && cmd_req_i && !cmd_ack_q;

        // The ack release runs in every state so a handshake finishes even after we stop receiving.
        if (byte_take) begin
            cmd_ack_d = 1'b1;
        end else if (cmd_ack_q && !cmd_req_i) begin
            cmd_ack_d = 1'b0;
        end

        if (in_get && !byte_take) begin
            byte_cnt_d = byte_cnt_q + 24'd1;
        end
        byte_timeout = in_get && !byte_take && (byte_cnt_q == BYTE_LIMIT);

        case (state_q)
            S_IDLE: begin
                if (byte_take) begin
                    if (cmd_data_i == OP_WRITE) begin
                        is_wr_d = 1'b1;
                        state_d = S_GET_ADDR;
                    end else if (cmd_data_i == OP_READ) begin
                        is_wr_d = 1'b0;
                        state_d = S_GET_ADDR;
                    end else begin
                        rsp_data_d = RSP_NAK;
                        rsp_two_d  = 1'b0;
                        tx_d       = TX_LOAD;
                        state_d    = S_SEND;
                    end
                end
            end
            S_GET_ADDR: begin
                if (byte_take) begin
                    reg_addr_d = cmd_data_i;
                    state_d    = is_wr_q ? S_GET_DHI : S_EXEC_RD;
                end else if (byte_timeout) begin
                    state_d = S_IDLE;
                end
            end
            S_GET_DHI: begin
                if (byte_take) begin
                    wr_data_d[15:8] = cmd_data_i;
                    state_d         = S_GET_DLO;
                end else if (byte_timeout) begin
                    state_d = S_IDLE;
                end
            end
            S_GET_DLO: begin
                if (byte_take) begin
                    wr_data_d[7:0] = cmd_data_i;
                    state_d        = S_EXEC_WR;
                end else if (byte_timeout) begin
                    state_d = S_IDLE;
                end
            end
            S_EXEC_WR: begin
                wr_en_d    = 1'b1;
                rsp_data_d = RSP_ACK;
                rsp_two_d  = 1'b0;
                tx_d       = TX_LOAD;
                state_d    = S_SEND;
            end
            S_EXEC_RD: begin
                rd_en_d  = 1'b1;
                rd_cnt_d = 8'h00;
                state_d  = S_WAIT_RD;
            end
            S_WAIT_RD: begin
                rd_cnt_d = rd_cnt_q + 8'd1;
                // Data arriving on the timeout cycle still wins over the NAK.
                if (reg_rd_valid_i) begin
                    rsp_data_d = reg_rd_data_i[15:8];
                    rsp_lo_d   = reg_rd_data_i[7:0];
                    rsp_two_d  = 1'b1;
                    tx_d       = TX_LOAD;
                    state_d    = S_SEND;
                end else if (rd_cnt_q == RD_LIMIT) begin
                    rsp_data_d = RSP_NAK;
                    rsp_two_d  = 1'b0;
                    tx_d       = TX_LOAD;
                    state_d    = S_SEND;
                end
            end
            S_SEND: begin
                // LOAD gives one cycle of stable data before the rise; GAP+LOAD keep req low two cycles.
                case (tx_q)
                    TX_LOAD: begin
                        rsp_req_d = 1'b1;
                        tx_d      = TX_REQ;
                    end
                    TX_REQ: begin
                        if (rsp_ack_i) begin
                            rsp_req_d = 1'b0;
                            if (rsp_two_q) begin
                                rsp_two_d  = 1'b0;
                                rsp_data_d = rsp_lo_q;
                                tx_d       = TX_GAP;
                            end else begin
                                tx_d    = TX_LOAD;
                                state_d = S_IDLE;
                            end
                        end
                    end
                    TX_GAP: begin
                        tx_d = TX_LOAD;
                    end
                    default: begin
                        tx_d = TX_LOAD;
                    end
                endcase
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cmd_ack_o     = cmd_ack_q;
    assign rsp_req_o     = rsp_req_q;
    assign rsp_data_o    = rsp_data_q;
    assign reg_addr_o    = reg_addr_q;
    assign reg_wr_data_o = wr_data_q;
    assign reg_wr_en_o   = wr_en_q;
    assign reg_rd_en_o   = rd_en_q;
    assign busy_o        = (state_q != S_IDLE);

endmodule
